axi_wr_arbiter: RTL and testbench

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

---
 rtl/axi_arb_pkg.sv | 29 ++
 rtl/axi_rr_arbiter.sv | 43 ++++
 rtl/axi_wr_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types for the two-master AXI write arbiter.
//   state_e : arbiter FSM states (IDLE/ADDR/DATA/RESP)
//   grant_t : one-hot slave-port owner, bit0 = m0, bit1 = m1, 00 = idle
`ifndef D_ID_WIDTH
`define D_ID_WIDTH 4
`endif
`ifndef D_ADDR_WIDTH
`define D_ADDR_WIDTH 32
`endif
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 32
`endif

package axi_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef logic [1:0] grant_t;

  localparam grant_t GNT_NONE = 2'b00;
  localparam grant_t GNT_M0   = 2'b01;
  localparam grant_t GNT_M1   = 2'b10;

  localparam int LEN_W = 8;
endpackage

// File: rtl/axi_rr_arbiter.sv
// Two-requester pick with last-grant memory.
//   clk/rst_n : clock, async active-low reset (last grant resets to m1 so m0 wins first)
//   req       : {m1, m0} request vector
//   upd       : pulse to record upd_gnt as the last winner
//   pick      : combinational one-hot winner for the current req
module axi_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  grant_t     upd_gnt,
  output grant_t     pick
);

  grant_t last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (upd && (upd_gnt != GNT_NONE)) last_d = upd_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= GNT_M1;
    else        last_q <= last_d;
  end

  // On a tie, round-robin hands the port to whoever did not own it last;
  // fixed priority always favours m0.
  always_comb begin
    pick = GNT_NONE;
    case (req)
      2'b01:   pick = GNT_M0;
      2'b10:   pick = GNT_M1;
      2'b11:   pick = (RR_EN && (last_q == GNT_M0)) ? GNT_M1 : GNT_M0;
      default: pick = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-master to one-slave AXI write arbiter, one transaction in flight.
//   ACLK/ARESETn      : clock, async active-low reset
//   m0_*/m1_*         : master AW/W inputs, AWREADY/WREADY/B* outputs, BREADY input
//   s_*               : shared slave AW/W outputs, BREADY output; AWREADY/WREADY/B* inputs
//   grant             : one-hot owner of the slave port (00 when idle)
//   busy              : FSM not in IDLE
//   err_wlast         : one-cycle pulse after a W beat whose WLAST disagrees with AWLEN
`ifndef D_ID_WIDTH
`define D_ID_WIDTH 4
`endif
`ifndef D_ADDR_WIDTH
`define D_ADDR_WIDTH 32
`endif
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 32
`endif

module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  // master 0
  input  logic [`D_ID_WIDTH-1:0]     m0_AWID,
  input  logic [`D_ADDR_WIDTH-1:0]   m0_AWADDR,
  input  logic [7:0]                 m0_AWLEN,
  input  logic [2:0]                 m0_AWSIZE,
  input  logic [1:0]                 m0_AWBURST,
  input  logic [2:0]                 m0_AWPROT,
  input  logic                       m0_AWVALID,
  output logic                       m0_AWREADY,
  input  logic [`D_ID_WIDTH-1:0]     m0_WID,
  input  logic [`D_DATA_WIDTH-1:0]   m0_WDATA,
  input  logic [`D_DATA_WIDTH/8-1:0] m0_WSTRB,
  input  logic                       m0_WLAST,
  input  logic                       m0_WVALID,
  output logic                       m0_WREADY,
  output logic [`D_ID_WIDTH-1:0]     m0_BID,
  output logic [1:0]                 m0_BRESP,
  output logic                       m0_BVALID,
  input  logic                       m0_BREADY,
  // master 1
  input  logic [`D_ID_WIDTH-1:0]     m1_AWID,
  input  logic [`D_ADDR_WIDTH-1:0]   m1_AWADDR,
  input  logic [7:0]                 m1_AWLEN,
  input  logic [2:0]                 m1_AWSIZE,
  input  logic [1:0]                 m1_AWBURST,
  input  logic [2:0]                 m1_AWPROT,
  input  logic                       m1_AWVALID,
  output logic                       m1_AWREADY,
  input  logic [`D_ID_WIDTH-1:0]     m1_WID,
  input  logic [`D_DATA_WIDTH-1:0]   m1_WDATA,
  input  logic [`D_DATA_WIDTH/8-1:0] m1_WSTRB,
  input  logic                       m1_WLAST,
  input  logic                       m1_WVALID,
  output logic                       m1_WREADY,
  output logic [`D_ID_WIDTH-1:0]     m1_BID,
  output logic [1:0]                 m1_BRESP,
  output logic                       m1_BVALID,
  input  logic                       m1_BREADY,
  // slave
  output logic [`D_ID_WIDTH-1:0]     s_AWID,
  output logic [`D_ADDR_WIDTH-1:0]   s_AWADDR,
  output logic [7:0]                 s_AWLEN,
  output logic [2:0]                 s_AWSIZE,
  output logic [1:0]                 s_AWBURST,
  output logic [2:0]                 s_AWPROT,
  output logic                       s_AWVALID,
  input  logic                       s_AWREADY,
  output logic [`D_ID_WIDTH-1:0]     s_WID,
  output logic [`D_DATA_WIDTH-1:0]   s_WDATA,
  output logic [`D_DATA_WIDTH/8-1:0] s_WSTRB,
  output logic                       s_WLAST,
  output logic                       s_WVALID,
  input  logic                       s_WREADY,
  input  logic [`D_ID_WIDTH-1:0]     s_BID,
  input  logic [1:0]                 s_BRESP,
  input  logic                       s_BVALID,
  output logic                       s_BREADY,
  // status
  output logic [1:0]                 grant,
  output logic                       busy,
  output logic                       err_wlast
);

  state_e           state_q, state_d;
  grant_t           grant_q, grant_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  grant_t pick;
  logic   upd;
  logic   sel;
  logic   in_addr, in_data, in_resp;
  logic   aw_hs, w_hs, b_hs;

  axi_rr_arbiter #(.RR_EN(RR_EN)) u_arb (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .req     ({m1_AWVALID, m0_AWVALID}),
    .upd     (upd),
    .upd_gnt (grant_q),
    .pick    (pick)
  );

  assign sel     = grant_q[1];
  assign in_addr = (state_q == ADDR);
  assign in_data = (state_q == DATA);
  assign in_resp = (state_q == RESP);

  // Slave-side payloads follow the owner all the time; only VALID/READY
  // are qualified by state so nothing leaks outside the owning phase.
  assign s_AWID    = sel ? m1_AWID    : m0_AWID;
  assign s_AWADDR  = sel ? m1_AWADDR  : m0_AWADDR;
  assign s_AWLEN   = sel ? m1_AWLEN   : m0_AWLEN;
  assign s_AWSIZE  = sel ? m1_AWSIZE  : m0_AWSIZE;
  assign s_AWBURST = sel ? m1_AWBURST : m0_AWBURST;
  assign s_AWPROT  = sel ? m1_AWPROT  : m0_AWPROT;
  assign s_AWVALID = in_addr & (sel ? m1_AWVALID : m0_AWVALID);

  assign s_WID    = sel ? m1_WID    : m0_WID;
  assign s_WDATA  = sel ? m1_WDATA  : m0_WDATA;
  assign s_WSTRB  = sel ? m1_WSTRB  : m0_WSTRB;
  assign s_WLAST  = sel ? m1_WLAST  : m0_WLAST;
  assign s_WVALID = in_data & (sel ? m1_WVALID : m0_WVALID);

  assign s_BREADY = in_resp & (sel ? m1_BREADY : m0_BREADY);

  assign m0_AWREADY = in_addr & grant_q[0] & s_AWREADY;
  assign m1_AWREADY = in_addr & grant_q[1] & s_AWREADY;
  assign m0_WREADY  = in_data & grant_q[0] & s_WREADY;
  assign m1_WREADY  = in_data & grant_q[1] & s_WREADY;

  assign m0_BID    = s_BID;
  assign m0_BRESP  = s_BRESP;
  assign m0_BVALID = in_resp & grant_q[0] & s_BVALID;
  assign m1_BID    = s_BID;
  assign m1_BRESP  = s_BRESP;
  assign m1_BVALID = in_resp & grant_q[1] & s_BVALID;

  assign aw_hs = s_AWVALID & s_AWREADY;
  assign w_hs  = s_WVALID  & s_WREADY;
  assign b_hs  = s_BREADY  & s_BVALID;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    upd     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick != GNT_NONE) begin
          grant_d = pick;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (aw_hs) begin
          cnt_d   = s_AWLEN;
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          if (cnt_q != '0) cnt_d = cnt_q - 8'd1;
          // Mismatch either way: WLAST early (cnt!=0) or missing (cnt==0).
          err_d = s_WLAST ^ (cnt_q == '0);
          if (s_WLAST) state_d = RESP;
        end
      end
      RESP: begin
        if (b_hs) begin
          upd     = 1'b1;
          grant_d = GNT_NONE;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      grant_q <= GNT_NONE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign err_wlast = err_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed, table-driven bench for axi_wr_arbiter. A round-robin instance
// is fully checked; a fixed-priority instance shares the inputs and has its
// grant checked where the expected value is meaningful.
`ifndef D_ID_WIDTH
`define D_ID_WIDTH 4
`endif
`ifndef D_ADDR_WIDTH
`define D_ADDR_WIDTH 32
`endif
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 32
`endif

module tb_axi_wr_arbiter;
  localparam int IW = `D_ID_WIDTH;
  localparam int AW = `D_ADDR_WIDTH;
  localparam int DW = `D_DATA_WIDTH;
  localparam logic [AW-1:0] A0 = AW'('h1000);
  localparam logic [AW-1:0] A1 = AW'('h2000);
  localparam logic [DW-1:0] D0 = DW'('hA0A0);
  localparam logic [DW-1:0] D1 = DW'('hB1B1);
  localparam logic [IW-1:0] SBID = IW'(5);

  logic ACLK = 1'b0, ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [IW-1:0] m0_AWID, m1_AWID, m0_WID, m1_WID, s_BID;
  logic [AW-1:0] m0_AWADDR, m1_AWADDR;
  logic [7:0] m0_AWLEN, m1_AWLEN;
  logic [2:0] m0_AWSIZE, m1_AWSIZE, m0_AWPROT, m1_AWPROT;
  logic [1:0] m0_AWBURST, m1_AWBURST, s_BRESP;
  logic m0_AWVALID, m1_AWVALID, m0_WLAST, m1_WLAST, m0_WVALID, m1_WVALID;
  logic m0_BREADY, m1_BREADY, s_AWREADY, s_WREADY, s_BVALID;
  logic [DW-1:0] m0_WDATA, m1_WDATA;
  logic [DW/8-1:0] m0_WSTRB, m1_WSTRB;

  // round-robin DUT outputs
  logic m0_AWREADY, m1_AWREADY, m0_WREADY, m1_WREADY, m0_BVALID, m1_BVALID;
  logic [IW-1:0] m0_BID, m1_BID, s_AWID, s_WID;
  logic [1:0] m0_BRESP, m1_BRESP, s_AWBURST, grant;
  logic [AW-1:0] s_AWADDR;
  logic [7:0] s_AWLEN;
  logic [2:0] s_AWSIZE, s_AWPROT;
  logic s_AWVALID, s_WLAST, s_WVALID, s_BREADY, busy, err_wlast;
  logic [DW-1:0] s_WDATA;
  logic [DW/8-1:0] s_WSTRB;

  // fixed-priority DUT outputs
  logic f_m0_AWREADY, f_m1_AWREADY, f_m0_WREADY, f_m1_WREADY, f_m0_BVALID, f_m1_BVALID;
  logic [IW-1:0] f_m0_BID, f_m1_BID, f_s_AWID, f_s_WID;
  logic [1:0] f_m0_BRESP, f_m1_BRESP, f_s_AWBURST, f_grant;
  logic [AW-1:0] f_s_AWADDR;
  logic [7:0] f_s_AWLEN;
  logic [2:0] f_s_AWSIZE, f_s_AWPROT;
  logic f_s_AWVALID, f_s_WLAST, f_s_WVALID, f_s_BREADY, f_busy, f_err_wlast;
  logic [DW-1:0] f_s_WDATA;
  logic [DW/8-1:0] f_s_WSTRB;

  axi_wr_arbiter #(.RR_EN(1'b1)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m0_AWID(m0_AWID), .m0_AWADDR(m0_AWADDR), .m0_AWLEN(m0_AWLEN), .m0_AWSIZE(m0_AWSIZE),
    .m0_AWBURST(m0_AWBURST), .m0_AWPROT(m0_AWPROT), .m0_AWVALID(m0_AWVALID), .m0_AWREADY(m0_AWREADY),
    .m0_WID(m0_WID), .m0_WDATA(m0_WDATA), .m0_WSTRB(m0_WSTRB), .m0_WLAST(m0_WLAST),
    .m0_WVALID(m0_WVALID), .m0_WREADY(m0_WREADY), .m0_BID(m0_BID), .m0_BRESP(m0_BRESP),
    .m0_BVALID(m0_BVALID), .m0_BREADY(m0_BREADY),
    .m1_AWID(m1_AWID), .m1_AWADDR(m1_AWADDR), .m1_AWLEN(m1_AWLEN), .m1_AWSIZE(m1_AWSIZE),
    .m1_AWBURST(m1_AWBURST), .m1_AWPROT(m1_AWPROT), .m1_AWVALID(m1_AWVALID), .m1_AWREADY(m1_AWREADY),
    .m1_WID(m1_WID), .m1_WDATA(m1_WDATA), .m1_WSTRB(m1_WSTRB), .m1_WLAST(m1_WLAST),
    .m1_WVALID(m1_WVALID), .m1_WREADY(m1_WREADY), .m1_BID(m1_BID), .m1_BRESP(m1_BRESP),
    .m1_BVALID(m1_BVALID), .m1_BREADY(m1_BREADY),
    .s_AWID(s_AWID), .s_AWADDR(s_AWADDR), .s_AWLEN(s_AWLEN), .s_AWSIZE(s_AWSIZE),
    .s_AWBURST(s_AWBURST), .s_AWPROT(s_AWPROT), .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
    .s_WID(s_WID), .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB), .s_WLAST(s_WLAST),
    .s_WVALID(s_WVALID), .s_WREADY(s_WREADY), .s_BID(s_BID), .s_BRESP(s_BRESP),
    .s_BVALID(s_BVALID), .s_BREADY(s_BREADY),
    .grant(grant), .busy(busy), .err_wlast(err_wlast)
  );

  axi_wr_arbiter #(.RR_EN(1'b0)) dut_fp (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m0_AWID(m0_AWID), .m0_AWADDR(m0_AWADDR), .m0_AWLEN(m0_AWLEN), .m0_AWSIZE(m0_AWSIZE),
    .m0_AWBURST(m0_AWBURST), .m0_AWPROT(m0_AWPROT), .m0_AWVALID(m0_AWVALID), .m0_AWREADY(f_m0_AWREADY),
    .m0_WID(m0_WID), .m0_WDATA(m0_WDATA), .m0_WSTRB(m0_WSTRB), .m0_WLAST(m0_WLAST),
    .m0_WVALID(m0_WVALID), .m0_WREADY(f_m0_WREADY), .m0_BID(f_m0_BID), .m0_BRESP(f_m0_BRESP),
    .m0_BVALID(f_m0_BVALID), .m0_BREADY(m0_BREADY),
    .m1_AWID(m1_AWID), .m1_AWADDR(m1_AWADDR), .m1_AWLEN(m1_AWLEN), .m1_AWSIZE(m1_AWSIZE),
    .m1_AWBURST(m1_AWBURST), .m1_AWPROT(m1_AWPROT), .m1_AWVALID(m1_AWVALID), .m1_AWREADY(f_m1_AWREADY),
    .m1_WID(m1_WID), .m1_WDATA(m1_WDATA), .m1_WSTRB(m1_WSTRB), .m1_WLAST(m1_WLAST),
    .m1_WVALID(m1_WVALID), .m1_WREADY(f_m1_WREADY), .m1_BID(f_m1_BID), .m1_BRESP(f_m1_BRESP),
    .m1_BVALID(f_m1_BVALID), .m1_BREADY(m1_BREADY),
    .s_AWID(f_s_AWID), .s_AWADDR(f_s_AWADDR), .s_AWLEN(f_s_AWLEN), .s_AWSIZE(f_s_AWSIZE),
    .s_AWBURST(f_s_AWBURST), .s_AWPROT(f_s_AWPROT), .s_AWVALID(f_s_AWVALID), .s_AWREADY(s_AWREADY),
    .s_WID(f_s_WID), .s_WDATA(f_s_WDATA), .s_WSTRB(f_s_WSTRB), .s_WLAST(f_s_WLAST),
    .s_WVALID(f_s_WVALID), .s_WREADY(s_WREADY), .s_BID(s_BID), .s_BRESP(s_BRESP),
    .s_BVALID(s_BVALID), .s_BREADY(f_s_BREADY),
    .grant(f_grant), .busy(f_busy), .err_wlast(f_err_wlast)
  );

  typedef struct {
    string      nm;
    bit         rst;
    logic [1:0] awv, wv, wl, br;
    logic       sawr, swr, sbv;
    logic [7:0] len;
    logic [1:0] gnt;
    logic       busy, saw, sw, sbr;
    logic [1:0] awr, wr, bv;
    logic       err;
    int         pg;   // expected fixed-priority grant, -1 = not checked
  } vec_t;

  vec_t tbl[$];
  int nvec = 0;
  int nerr = 0;

  task automatic v(input string nm, input bit rst,
                   input logic [1:0] awv, wv, wl, br, input logic sawr, swr, sbv,
                   input logic [7:0] len,
                   input logic [1:0] gnt, input logic bsy, saw, sw, sbr,
                   input logic [1:0] awr, wr, bv, input logic err, input int pg);
    vec_t t;
    t.nm = nm; t.rst = rst; t.awv = awv; t.wv = wv; t.wl = wl; t.br = br;
    t.sawr = sawr; t.swr = swr; t.sbv = sbv; t.len = len;
    t.gnt = gnt; t.busy = bsy; t.saw = saw; t.sw = sw; t.sbr = sbr;
    t.awr = awr; t.wr = wr; t.bv = bv; t.err = err; t.pg = pg;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  initial begin
    m0_AWID = IW'(1); m1_AWID = IW'(2); m0_WID = IW'(1); m1_WID = IW'(2);
    m0_AWADDR = A0; m1_AWADDR = A1; m0_WDATA = D0; m1_WDATA = D1;
    m0_AWSIZE = 3'd2; m1_AWSIZE = 3'd2; m0_AWBURST = 2'b01; m1_AWBURST = 2'b01;
    m0_AWPROT = 3'd0; m1_AWPROT = 3'd0; m0_WSTRB = '1; m1_WSTRB = '1;
    m0_AWLEN = 8'd0; m1_AWLEN = 8'd0;
    m0_AWVALID = 0; m1_AWVALID = 0; m0_WVALID = 0; m1_WVALID = 0; m0_WLAST = 0; m1_WLAST = 0;
    m0_BREADY = 0; m1_BREADY = 0; s_AWREADY = 0; s_WREADY = 0; s_BVALID = 0;
    s_BID = SBID; s_BRESP = 2'b00;

    //  name   rst awv   wv    wl    br    sawr swr sbv len | gnt  bsy saw sw sbr awr   wr    bv    err pg
    // m0 alone, 4 beats with one W stall
    v("a0", 0, 2'b00,2'b00,2'b00,2'b00, 0,0,0, 3, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0, 0);
    v("a1", 0, 2'b01,2'b00,2'b00,2'b00, 0,0,0, 3, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0, 0);
    v("a2", 0, 2'b01,2'b00,2'b00,2'b00, 1,0,0, 3, 2'b01,1,1,0,0, 2'b01,2'b00,2'b00,0, 1);
    v("a3", 0, 2'b00,2'b01,2'b00,2'b00, 0,1,0, 3, 2'b01,1,0,1,0, 2'b00,2'b01,2'b00,0, 1);
    v("a4", 0, 2'b00,2'b01,2'b00,2'b00, 0,1,0, 3, 2'b01,1,0,1,0, 2'b00,2'b01,2'b00,0, 1);
    v("a5", 0, 2'b00,2'b01,2'b00,2'b00, 0,0,0, 3, 2'b01,1,0,1,0, 2'b00,2'b00,2'b00,0, 1);
    v("a6", 0, 2'b00,2'b01,2'b00,2'b00, 0,1,0, 3, 2'b01,1,0,1,0, 2'b00,2'b01,2'b00,0, 1);
    v("a7", 0, 2'b00,2'b01,2'b01,2'b00, 0,1,0, 3, 2'b01,1,0,1,0, 2'b00,2'b01,2'b00,0, 1);
    v("a8", 0, 2'b00,2'b00,2'b00,2'b01, 0,0,1, 3, 2'b01,1,0,0,1, 2'b00,2'b00,2'b01,0, 1);
    v("a9", 0, 2'b00,2'b00,2'b00,2'b00, 0,0,0, 3, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0, 0);
    // simultaneous requests twice: RR gives 01,10; fixed gives 01,01
    v("br", 1, 2'b00,2'b00,2'b00,2'b00, 0,0,0, 0, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0, 0);
    v("b1", 0, 2'b11,2'b00,2'b00,2'b00, 0,0,0, 0, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0, 0);
    v("b2", 0, 2'b11,2'b00,2'b00,2'b00, 1,0,0, 0, 2'b01,1,1,0,0, 2'b01,2'b00,2'b00,0, 1);
    v("b3", 0, 2'b10,2'b01,2'b01,2'b00, 0,1,0, 0, 2'b01,1,0,1,0, 2'b00,2'b01,2'b00,0, 1);
    v("b4", 0, 2'b10,2'b00,2'b00,2'b01, 0,0,1, 0, 2'b01,1,0,0,1, 2'b00,2'b00,2'b01,0, 1);
    v("b5", 0, 2'b11,2'b00,2'b00,2'b00, 0,0,0, 0, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0, 0);
    v("b6", 0, 2'b11,2'b00,2'b00,2'b00, 1,0,0, 0, 2'b10,1,1,0,0, 2'b10,2'b00,2'b00,0, 1);
    v("b7", 0, 2'b01,2'b10,2'b10,2'b00, 0,1,0, 0, 2'b10,1,0,1,0, 2'b00,2'b10,2'b00,0, 1);
    v("b8", 0, 2'b01,2'b00,2'b00,2'b10, 0,0,1, 0, 2'b10,1,0,0,1, 2'b00,2'b00,2'b10,0, 1);
    v("b9", 0, 2'b00,2'b00,2'b00,2'b00, 0,0,0, 0, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0, 1);
    // m1 waits while m0 owns the port; then m1 sends WLAST early
    v("cr", 1, 2'b00,2'b00,2'b00,2'b00, 0,0,0, 1, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0, 0);
    v("c1", 0, 2'b01,2'b00,2'b00,2'b00, 0,0,0, 1, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0,-1);
    v("c2", 0, 2'b01,2'b00,2'b00,2'b00, 1,0,0, 1, 2'b01,1,1,0,0, 2'b01,2'b00,2'b00,0,-1);
    v("c3", 0, 2'b10,2'b01,2'b00,2'b00, 1,1,0, 1, 2'b01,1,0,1,0, 2'b00,2'b01,2'b00,0,-1);
    v("c4", 0, 2'b10,2'b01,2'b01,2'b00, 1,1,0, 1, 2'b01,1,0,1,0, 2'b00,2'b01,2'b00,0,-1);
    v("c5", 0, 2'b10,2'b00,2'b00,2'b00, 1,0,1, 1, 2'b01,1,0,0,0, 2'b00,2'b00,2'b01,0,-1);
    v("c6", 0, 2'b10,2'b00,2'b00,2'b01, 1,0,1, 1, 2'b01,1,0,0,1, 2'b00,2'b00,2'b01,0,-1);
    v("c7", 0, 2'b10,2'b00,2'b00,2'b00, 1,0,0, 1, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0,-1);
    v("c8", 0, 2'b10,2'b00,2'b00,2'b00, 1,0,0, 1, 2'b10,1,1,0,0, 2'b10,2'b00,2'b00,0,-1);
    v("c9", 0, 2'b00,2'b10,2'b10,2'b00, 0,1,0, 1, 2'b10,1,0,1,0, 2'b00,2'b10,2'b00,0,-1);
    v("c10",0, 2'b00,2'b00,2'b00,2'b10, 0,0,1, 1, 2'b10,1,0,0,1, 2'b00,2'b00,2'b10,1,-1);
    v("c11",0, 2'b00,2'b00,2'b00,2'b00, 0,0,0, 1, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0,-1);
    // reset after 2 of 4 beats, then a fresh single-beat burst missing WLAST once
    v("dr", 1, 2'b00,2'b00,2'b00,2'b00, 0,0,0, 3, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0, 0);
    v("d1", 0, 2'b01,2'b00,2'b00,2'b00, 0,0,0, 3, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0,-1);
    v("d2", 0, 2'b01,2'b00,2'b00,2'b00, 1,0,0, 3, 2'b01,1,1,0,0, 2'b01,2'b00,2'b00,0,-1);
    v("d3", 0, 2'b00,2'b01,2'b00,2'b00, 0,1,0, 3, 2'b01,1,0,1,0, 2'b00,2'b01,2'b00,0,-1);
    v("d4", 0, 2'b00,2'b01,2'b00,2'b00, 0,1,0, 3, 2'b01,1,0,1,0, 2'b00,2'b01,2'b00,0,-1);
    v("d5", 1, 2'b00,2'b01,2'b00,2'b01, 1,1,1, 3, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0, 0);
    v("d6", 0, 2'b11,2'b00,2'b00,2'b00, 0,0,0, 0, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0,-1);
    v("d7", 0, 2'b11,2'b00,2'b00,2'b00, 1,0,0, 0, 2'b01,1,1,0,0, 2'b01,2'b00,2'b00,0,-1);
    v("d8", 0, 2'b10,2'b01,2'b00,2'b00, 0,1,0, 0, 2'b01,1,0,1,0, 2'b00,2'b01,2'b00,0,-1);
    v("d9", 0, 2'b10,2'b01,2'b01,2'b00, 0,1,0, 0, 2'b01,1,0,1,0, 2'b00,2'b01,2'b00,1,-1);
    v("d10",0, 2'b10,2'b00,2'b00,2'b01, 0,0,1, 0, 2'b01,1,0,0,1, 2'b00,2'b00,2'b01,0,-1);
    v("d11",0, 2'b10,2'b00,2'b00,2'b00, 0,0,0, 0, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0,-1);
    // B held back by the owner for 5 cycles while m0 waits
    v("e1", 0, 2'b10,2'b00,2'b00,2'b00, 1,0,0, 0, 2'b10,1,1,0,0, 2'b10,2'b00,2'b00,0,-1);
    v("e2", 0, 2'b01,2'b10,2'b10,2'b00, 0,1,0, 0, 2'b10,1,0,1,0, 2'b00,2'b10,2'b00,0,-1);
    for (int k = 0; k < 5; k++)
      v("e3", 0, 2'b01,2'b00,2'b00,2'b01, 1,0,1, 0, 2'b10,1,0,0,0, 2'b00,2'b00,2'b10,0,-1);
    v("e8", 0, 2'b01,2'b00,2'b00,2'b10, 0,0,1, 0, 2'b10,1,0,0,1, 2'b00,2'b00,2'b10,0,-1);
    v("e9", 0, 2'b00,2'b00,2'b00,2'b00, 0,0,0, 0, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,0,-1);

    repeat (3) @(negedge ACLK);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge ACLK);
      ARESETn = !tbl[i].rst;
      {m1_AWVALID, m0_AWVALID} = tbl[i].awv;
      {m1_WVALID,  m0_WVALID}  = tbl[i].wv;
      {m1_WLAST,   m0_WLAST}   = tbl[i].wl;
      {m1_BREADY,  m0_BREADY}  = tbl[i].br;
      s_AWREADY = tbl[i].sawr; s_WREADY = tbl[i].swr; s_BVALID = tbl[i].sbv;
      m0_AWLEN = tbl[i].len; m1_AWLEN = tbl[i].len;
      #1;
      nvec++;
      chk(tbl[i].nm, "grant",     64'(grant),                    64'(tbl[i].gnt));
      chk(tbl[i].nm, "busy",      64'(busy),                     64'(tbl[i].busy));
      chk(tbl[i].nm, "s_AWVALID", 64'(s_AWVALID),                64'(tbl[i].saw));
      chk(tbl[i].nm, "s_WVALID",  64'(s_WVALID),                 64'(tbl[i].sw));
      chk(tbl[i].nm, "s_BREADY",  64'(s_BREADY),                 64'(tbl[i].sbr));
      chk(tbl[i].nm, "AWREADY",   64'({m1_AWREADY, m0_AWREADY}), 64'(tbl[i].awr));
      chk(tbl[i].nm, "WREADY",    64'({m1_WREADY, m0_WREADY}),   64'(tbl[i].wr));
      chk(tbl[i].nm, "BVALID",    64'({m1_BVALID, m0_BVALID}),   64'(tbl[i].bv));
      chk(tbl[i].nm, "err_wlast", 64'(err_wlast),                64'(tbl[i].err));
      if (tbl[i].pg >= 0)
        chk(tbl[i].nm, "fp_grant", 64'(f_grant), 64'(tbl[i].pg));
      if (tbl[i].saw) begin
        chk(tbl[i].nm, "s_AWADDR", 64'(s_AWADDR), 64'(tbl[i].gnt[1] ? A1 : A0));
        chk(tbl[i].nm, "s_AWLEN",  64'(s_AWLEN),  64'(tbl[i].len));
      end
      if (tbl[i].sw)
        chk(tbl[i].nm, "s_WDATA", 64'(s_WDATA), 64'(tbl[i].gnt[1] ? D1 : D0));
      if (tbl[i].bv[0]) begin
        chk(tbl[i].nm, "m0_BRESP", 64'(m0_BRESP), 64'(2'b00));
        chk(tbl[i].nm, "m0_BID",   64'(m0_BID),   64'(SBID));
      end
      if (tbl[i].bv[1])
        chk(tbl[i].nm, "m1_BID", 64'(m1_BID), 64'(SBID));
    end

    // Request pulse that drops before any clock edge must not be granted.
    @(negedge ACLK);
    {m1_AWVALID, m0_AWVALID} = 2'b00; {m1_WVALID, m0_WVALID} = 2'b00;
    {m1_BREADY, m0_BREADY} = 2'b00; s_AWREADY = 0; s_WREADY = 0; s_BVALID = 0;
    m0_AWVALID = 1'b1;
    #2 m0_AWVALID = 1'b0;
    @(negedge ACLK); #1;
    nvec++;
    chk("wd", "grant", 64'(grant), 64'(2'b00));
    chk("wd", "busy",  64'(busy),  64'(1'b0));

    // Asynchronous reset while in ADDR clears outputs with no clock edge.
    @(negedge ACLK);
    m0_AWVALID = 1'b1; s_AWREADY = 1'b0;
    @(negedge ACLK); #1;
    nvec++;
    chk("ar", "grant_pre", 64'(grant),     64'(2'b01));
    chk("ar", "saw_pre",   64'(s_AWVALID), 64'(1'b1));
    s_AWREADY = 1'b1;
    ARESETn = 1'b0;
    #1;
    nvec++;
    chk("ar", "grant",      64'(grant),      64'(2'b00));
    chk("ar", "busy",       64'(busy),       64'(1'b0));
    chk("ar", "s_AWVALID",  64'(s_AWVALID),  64'(1'b0));
    chk("ar", "m0_AWREADY", 64'(m0_AWREADY), 64'(1'b0));
    @(negedge ACLK);
    ARESETn = 1'b1; m0_AWVALID = 1'b0; s_AWREADY = 1'b0;
    @(negedge ACLK);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
